// File: rtl/ipv6_dispatch_node.sv
// ipv6_dispatch_node: buffered NoC endpoint that classifies packets by EtherType and dispatches IPv6 round-robin.
// Optional feature macro: DISPATCH_DROP_NON_IPV6_EN drops non-IPv6 packets instead of sending them to DEFAULT_DEST.
module ipv6_dispatch_node #(
    parameter int DATA_WIDTH   = 512,
    parameter int NOC_WIDTH    = 600,
    parameter int NUM_VC       = 2,
    parameter int NOC_RADIX    = 16,
    parameter int NUM_SRC      = 4,
    parameter int DEST [NUM_SRC] = '{8, 9, 10, 11},
    parameter int DEFAULT_DEST = 0,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NOC_WIDTH-1:0] i_data_in,
    input  logic                 i_valid_in,
    output logic                 i_ready_out,
    output logic [NOC_WIDTH-1:0] o_data_out,
    output logic                 o_valid_out,
    input  logic                 o_ready_in,
    output logic [31:0]          o_fwd_cnt,
    output logic [31:0]          o_drop_cnt
);

    localparam int EMPTY_W = $clog2(DATA_WIDTH / 8);
    localparam int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int DST_W   = $clog2(NOC_RADIX);
    localparam int LOW_W   = DATA_WIDTH + 2 + EMPTY_W;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = AW + 1;
    localparam int RR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

`ifdef DISPATCH_DROP_NON_IPV6_EN
    localparam bit DROP_NON_IPV6 = 1'b1;
`else
    localparam bit DROP_NON_IPV6 = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    // Destination table flattened into DST_W-bit entries.
    logic [DST_W-1:0] dest_table [NUM_SRC];
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_dest
            assign dest_table[gi] = DST_W'(DEST[gi]);
        end
    endgenerate

    // Input FIFO: only the payload/sop/eop/empty fields are stored.
    logic [LOW_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             ready_reg;
    logic [LOW_W-1:0] head_reg;
    logic             head_valid_reg;
    logic             push, pop;
    logic             unused_hi;

    assign unused_hi   = ^i_data_in[NOC_WIDTH-1:LOW_W];
    assign i_ready_out = ready_reg;
    assign push        = i_valid_in && ready_reg;
    assign rd_ptr_next = rd_ptr_reg + AW'(pop);
    assign count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_data_in[LOW_W-1:0];
        end
        head_reg <= mem[rd_ptr_next];
    end

    // head_reg is valid only for entries written before this edge, so a
    // same-cycle write to the read address is never seen as stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            ready_reg      <= 1'b0;
            head_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            ready_reg      <= (count_next < CNT_W'(FIFO_DEPTH));
            head_valid_reg <= (count_reg != CNT_W'(pop));
        end
    end

    // Classifier / dispatcher
    state_t               state_reg, state_next;
    logic [DST_W-1:0]     dst_reg, dst_next;
    logic [VC_W-1:0]      vc_reg, vc_next;
    logic [RR_W-1:0]      rr_reg, rr_next;
    logic [NOC_WIDTH-1:0] out_data_reg, out_data_next;
    logic                 out_valid_reg, out_valid_next;
    logic [31:0]          fwd_cnt_reg, drop_cnt_reg;
    logic                 fwd_inc, drop_inc, load;
    logic [DST_W-1:0]     out_dst;
    logic [VC_W-1:0]      out_vc;
    logic                 head_sop, head_eop, is_ipv6, can_load;

    assign head_sop = head_reg[DATA_WIDTH];
    assign head_eop = head_reg[DATA_WIDTH+1];
    assign is_ipv6  = (head_reg[DATA_WIDTH-97 -: 16] == 16'h86DD);
    assign can_load = !out_valid_reg || o_ready_in;

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        load       = 1'b0;
        fwd_inc    = 1'b0;
        drop_inc   = 1'b0;
        out_dst    = dst_reg;
        out_vc     = vc_reg;
        dst_next   = dst_reg;
        vc_next    = vc_reg;
        rr_next    = rr_reg;
        case (state_reg)
            IDLE: begin
                if (head_valid_reg) begin
                    if (!head_sop) begin
                        pop = 1'b1;
                    end else if (!is_ipv6 && DROP_NON_IPV6) begin
                        pop      = 1'b1;
                        drop_inc = 1'b1;
                        if (!head_eop) begin
                            state_next = DROP;
                        end
                    end else if (can_load) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        fwd_inc = 1'b1;
                        if (is_ipv6) begin
                            out_dst = dest_table[rr_reg];
                            out_vc  = '0;
                            rr_next = (rr_reg == RR_W'(NUM_SRC - 1)) ? '0 : rr_reg + RR_W'(1);
                        end else begin
                            out_dst = DST_W'(DEFAULT_DEST);
                            out_vc  = VC_W'(NUM_VC - 1);
                        end
                        dst_next = out_dst;
                        vc_next  = out_vc;
                        if (!head_eop) begin
                            state_next = FWD;
                        end
                    end
                end
            end
            FWD: begin
                if (head_valid_reg && can_load) begin
                    pop  = 1'b1;
                    load = 1'b1;
                    if (head_eop) begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (head_valid_reg) begin
                    pop = 1'b1;
                    if (head_eop) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        if (load) begin
            out_data_next                              = '0;
            out_data_next[LOW_W-1:0]                   = head_reg;
            out_data_next[NOC_WIDTH-1 -: DST_W]        = out_dst;
            out_data_next[NOC_WIDTH-DST_W-1 -: VC_W]   = out_vc;
            out_valid_next                             = 1'b1;
        end else if (o_ready_in) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            dst_reg       <= '0;
            vc_reg        <= '0;
            rr_reg        <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            fwd_cnt_reg   <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            dst_reg       <= dst_next;
            vc_reg        <= vc_next;
            rr_reg        <= rr_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            fwd_cnt_reg   <= fwd_cnt_reg + 32'(fwd_inc);
            drop_cnt_reg  <= drop_cnt_reg + 32'(drop_inc);
        end
    end

    assign o_data_out  = out_data_reg;
    assign o_valid_out = out_valid_reg;
    assign o_fwd_cnt   = fwd_cnt_reg;
    assign o_drop_cnt  = drop_cnt_reg;

endmodule
